// File: rtl/apb5_requester_arbiter_if.sv
// Signal bundle between the local command sources, the APB5 requester arbiter and the APB5 completer.
// Handshake: command i transfers on a rising PCLK edge where req_valid[i] && req_ready[i]; req_* of a source stay stable while its req_valid is high and unaccepted; rsp_valid is a one-cycle pulse with no back-pressure.
interface apb5_requester_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0]            req_write;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic [NUM_REQ*STRB_WIDTH-1:0] req_strb;
    logic [NUM_REQ*3-1:0]          req_prot;

    logic [NUM_REQ-1:0]            rsp_valid;
    logic [DATA_WIDTH-1:0]         rsp_rdata;
    logic                          rsp_slverr;

    logic                          PWAKEUP;
    logic                          PSEL;
    logic                          PENABLE;
    logic [ADDR_WIDTH-1:0]         PADDR;
    logic                          PWRITE;
    logic [DATA_WIDTH-1:0]         PWDATA;
    logic [STRB_WIDTH-1:0]         PSTRB;
    logic [2:0]                    PPROT;
    logic [DATA_WIDTH-1:0]         PRDATA;
    logic                          PREADY;
    logic                          PSLVERR;

    logic [1:0]                    dbg_state;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        output req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        output PWAKEUP, PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR,
        output dbg_state
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, req_strb, req_prot,
        input  req_ready, rsp_valid, rsp_rdata, rsp_slverr,
        input  PWAKEUP, PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR,
        input  dbg_state
    );
endinterface

// File: rtl/apb5_requester_arbiter.sv
// Round-robin arbiter sharing one APB5 requester port between NUM_REQ local command sources.
// Sequences IDLE/SETUP/ACCESS, drives PWAKEUP and returns PRDATA/PSLVERR to the granted source.
module apb5_requester_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input logic                      PCLK,
    input logic                      PRESET,
    apb5_requester_arbiter_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [IDX_WIDTH-1:0]  rr_ptr;
    logic [IDX_WIDTH-1:0]  owner;
    logic [IDX_WIDTH-1:0]  win_idx;
    logic [IDX_WIDTH-1:0]  ptr_next;
    logic [IDX_WIDTH:0]    scan;
    logic                  win_found;
    logic                  grant_en;
    logic                  grant;
    logic                  xfer_done;

    logic [ADDR_WIDTH-1:0] win_addr;
    logic                  win_write;
    logic [DATA_WIDTH-1:0] win_wdata;
    logic [STRB_WIDTH-1:0] win_strb;
    logic [2:0]            win_prot;

    // Scan from rr_ptr upward with wrap-around; the first requesting source wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        scan      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr_ptr} + (IDX_WIDTH + 1)'(k);
            if (scan >= (IDX_WIDTH + 1)'(NUM_REQ)) begin
                scan = scan - (IDX_WIDTH + 1)'(NUM_REQ);
            end
            if (!win_found && bus.req_valid[scan[IDX_WIDTH-1:0]]) begin
                win_found = 1'b1;
                win_idx   = scan[IDX_WIDTH-1:0];
            end
        end
    end

    always_comb begin
        win_addr  = bus.req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
        win_write = bus.req_write[win_idx];
        win_wdata = win_write ? bus.req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
        win_strb  = win_write ? bus.req_strb[win_idx*STRB_WIDTH +: STRB_WIDTH] : '0;
        win_prot  = bus.req_prot[win_idx*3 +: 3];
        ptr_next  = (win_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end

    // A new command can only be taken when the bus is free or the current transfer ends now.
    assign grant_en  = !PRESET &&
                       ((state == ST_IDLE) || ((state == ST_ACCESS) && bus.PREADY));
    assign grant     = grant_en && win_found;
    assign xfer_done = (state == ST_ACCESS) && bus.PREADY;

    always_comb begin
        bus.req_ready = '0;
        if (grant) begin
            bus.req_ready[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (grant) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (bus.PREADY) state_next = grant ? ST_SETUP : ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state          <= ST_IDLE;
            rr_ptr         <= '0;
            owner          <= '0;
            bus.PSEL       <= 1'b0;
            bus.PENABLE    <= 1'b0;
            bus.PWAKEUP    <= 1'b0;
            bus.PADDR      <= '0;
            bus.PWRITE     <= 1'b0;
            bus.PWDATA     <= '0;
            bus.PSTRB      <= '0;
            bus.PPROT      <= '0;
            bus.rsp_valid  <= '0;
            bus.rsp_rdata  <= '0;
            bus.rsp_slverr <= 1'b0;
        end else begin
            state       <= state_next;
            bus.PSEL    <= (state_next != ST_IDLE);
            bus.PENABLE <= (state_next == ST_ACCESS);
            bus.PWAKEUP <= (|bus.req_valid) || (state_next != ST_IDLE);

            // Response goes out the cycle after PREADY, tagged with the owner captured at grant.
            bus.rsp_valid <= '0;
            if (xfer_done) begin
                bus.rsp_valid[owner] <= 1'b1;
                bus.rsp_rdata        <= bus.PWRITE ? '0 : bus.PRDATA;
                bus.rsp_slverr       <= bus.PSLVERR;
            end

            // APB address/data registers keep their last value while the bus is idle.
            if (grant) begin
                bus.PADDR  <= win_addr;
                bus.PWRITE <= win_write;
                bus.PWDATA <= win_wdata;
                bus.PSTRB  <= win_strb;
                bus.PPROT  <= win_prot;
                owner      <= win_idx;
                rr_ptr     <= ptr_next;
            end
        end
    end

    assign bus.dbg_state = state;
endmodule

// File: doc/apb5_requester_arbiter.md
Name: apb5_requester_arbiter

Overview:
- Shares one APB5 Requester port between NUM_REQ local command sources, using round-robin arbitration.
- Sequences APB5 IDLE/SETUP/ACCESS phases, handles PWAKEUP, and routes PRDATA/PSLVERR back to the granted source.
- Sits between internal masters (test sequencers or DUT-side controllers) and the APB5 bus used by the b2b bench.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
ADDR_WIDTH, 8, PADDR width
DATA_WIDTH, 32, PWDATA/PRDATA width (8, 16 or 32)

Ports:
PCLK  input  1  bus clock, all logic on rising edge
PRESET  input  1  asynchronous reset, active-high
req_valid  input  NUM_REQ  per-requester command valid
req_ready  output  NUM_REQ  command accepted this cycle (one-hot)
req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice i
req_write  input  NUM_REQ  1=write
req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data
req_strb  input  NUM_REQ*DATA_WIDTH/8  packed write strobes
req_prot  input  NUM_REQ*3  packed PPROT
rsp_valid  output  NUM_REQ  one-cycle response pulse to the owning requester
rsp_rdata  output  DATA_WIDTH  read data, valid with rsp_valid
rsp_slverr  output  1  PSLVERR of the completed transfer, valid with rsp_valid
PWAKEUP  output  1  APB5 wake-up
PSEL  output  1  APB select
PENABLE  output  1  APB enable
PADDR  output  ADDR_WIDTH  APB address
PWRITE  output  1  APB direction
PWDATA  output  DATA_WIDTH  APB write data
PSTRB  output  DATA_WIDTH/8  APB strobes
PPROT  output  3  APB protection
PRDATA  input  DATA_WIDTH  completer read data
PREADY  input  1  completer ready
PSLVERR  input  1  completer error

Behaviour:
- Reset (PRESET high, asynchronous): state=IDLE. All outputs are 0. rr_ptr=0. Takes effect mid-transfer immediately. The in-flight response is dropped and no rsp_valid is generated.
- States:
  - IDLE: PSEL=0.
  - SETUP: PSEL=1, PENABLE=0.
  - ACCESS: PSEL=1, PENABLE=1.
- Grant:
  - Evaluated combinationally in IDLE, and in ACCESS when PREADY=1.
  - Winner is the first set req_valid bit searching from rr_ptr upward with wrap-around.
  - req_ready[winner]=1 in that cycle only; at most one bit is set.
  - On the accepting edge, req_* of the winner are captured into PADDR/PWRITE/PWDATA/PSTRB/PPROT, state goes to SETUP, and rr_ptr=winner+1 (mod NUM_REQ).
- Read commands drive PWDATA=0 and PSTRB=0, regardless of req_wdata/req_strb.
- SETUP goes to ACCESS unconditionally after 1 cycle.
- ACCESS with PREADY=0: hold, with all APB outputs stable.
- ACCESS with PREADY=1:
  - Capture PRDATA (reads; 0 for writes) and PSLVERR.
  - In the next cycle assert rsp_valid[owner]=1, rsp_rdata and rsp_slverr for exactly one cycle.
  - Next state is SETUP if a grant occurs in the same cycle (back-to-back, PSEL stays 1, PENABLE drops to 0); otherwise IDLE.
- Minimum transfer: accept at cycle 0, SETUP at 1, ACCESS at 2, rsp_valid at 3 when PREADY=1 at cycle 2.
- APB outputs hold their last value in IDLE (no required zeroing after reset), except PSEL=PENABLE=0.
- PWAKEUP:
  - Registered. Next value is 1 if any req_valid is set or state is not IDLE (after the next-state update).
  - Therefore PWAKEUP rises no later than the cycle PSEL rises and stays 1 throughout a transfer.
  - Drops to 0 the cycle after return to IDLE with no req_valid.
- A requester may hold req_valid across its own response. Its next command is arbitrated normally and does not skip rr order.
- rsp_valid for transfer N and the SETUP of transfer N+1 occur in the same cycle during back-to-back operation.
- NUM_REQ=1 degenerates to a pass-through sequencer.

Test Plan:
- Single write, requester 0: addr=0x10, wdata=0xDEADBEEF, strb=0xF, PREADY=1 -> SETUP at cycle 1, ACCESS at cycle 2, rsp_valid=01 at cycle 3, slverr=0.
- Read with wait states: requester 1 reads 0x20, PREADY low 3 cycles, PRDATA=0x12345678 -> ACCESS held 4 cycles with stable APB outputs, rsp_rdata=0x12345678, PSTRB=0, PWDATA=0.
- Contention: both req_valid=1 continuously from reset -> grants alternate 0,1,0,1, back-to-back with no IDLE cycle, PSEL stays 1 across 4 transfers.
- Error: PSLVERR=1 on requester 1's write -> rsp_valid=10 with rsp_slverr=1; the next transfer has rsp_slverr=0.
- Wake-up: req_valid rises at cycle 5 -> PWAKEUP=1 by cycle 6 (same cycle as PSEL). It deasserts 1 cycle after IDLE with no requests.
- Reset mid-ACCESS: PRESET pulsed with PREADY=0 -> PSEL, PENABLE, PWAKEUP and rsp_valid go to 0 immediately with no response. After release, the first grant goes to requester 0.
